move_segment_queue: RTL and testbench
=====================================

# move_segment_queue

Command-assembly and buffering stage directly upstream of the DDA step executor. Consumes 64-bit little-endian words from the SPI word handler, assembles four-word coordinated-step commands (header, duration, increment, increment-increment), and queues complete segments in a FIFO. The DDA pops segments through a valid/ready handshake. The block also returns the encoder snapshot on the SPI reply word and drives buffer flow-control flags.

## Interface
- DEPTH_BITS, 2: log2 of queue depth, so DEPTH = 4 segments.
- CMD_STEP, 8'h01: header byte (word[63:56]) identifying a coordinated-step command.
- wb_clk_i  in  1  sole clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- word_valid  in  1  single-cycle strobe: word_data holds a newly received SPI word.
- word_data  in  64  received word.
- encoder_count  in  64  signed live encoder count.
- flush  in  1  synchronous halt: discards the queue and any partial command.
- reply_data  out  64  word to load for the next SPI transfer.
- seg_valid  out  1  queue non-empty; head segment presented.
- seg_ready  in  1  DDA accepts head segment.
- seg_dir  out  1  head direction bit.
- seg_duration  out  64  head tick count.
- seg_increment  out  64  signed head increment.
- seg_incinc  out  64  signed head increment-increment.
- count  out  DEPTH_BITS+1  number of queued segments, 0..DEPTH.
- buffer_dtr  out  1  high when count < DEPTH.
- overflow  out  1  sticky: a completed segment was dropped because the queue was full.

## Operation
- FSM states: HDR, DUR, INC, IIN. Each state advances only on word_valid.
- HDR, header == CMD_STEP: latch dir = word[0], snapshot encoder_count into enc_snap, reply_data <= 0, go to DUR.
- HDR, any other header: ignore the word, reply_data <= 0, stay in HDR.
- DUR: latch duration = word, reply_data <= 0, go to INC.
- INC: latch increment = word, reply_data <= enc_snap, go to IIN.
- IIN: reply_data <= 0, go to HDR.
  - If count < DEPTH: write {dir, duration, increment, word} at wr_ptr, then wr_ptr++.
  - Otherwise drop the segment and set overflow.
- FIFO: circular, wr_ptr and rd_ptr are DEPTH_BITS wide and wrap modulo DEPTH. count is tracked separately.
- Pop: occurs when seg_valid & seg_ready. rd_ptr++.
- seg_* outputs are driven combinationally from mem[rd_ptr]. Their values are undefined while seg_valid = 0.
- Same cycle push and pop: count unchanged, both pointers advance. A push while full is still refused even if a pop happens that cycle, so the full check uses pre-pop count.
- Pop while empty is ignored.
- flush takes priority over word_valid and pop:
  - wr_ptr, rd_ptr and count go to 0.
  - FSM goes to HDR.
  - overflow clears.
  - reply_data goes to 0.
  - Memory contents are not cleared.
- No arithmetic on payloads: all 64-bit fields pass through bit-exact.

## Timing
- Reset values: FSM = HDR; count, pointers, reply_data, enc_snap = 0; seg_valid = 0; overflow = 0; buffer_dtr = 1. Reset is honoured asynchronously at any point mid-command.
- Push latency: seg_valid and count update on the edge that samples the IIN word_valid. They are visible the next cycle.
- Pop: count decrements, and the new head appears on seg_*, the cycle after the accepting edge.
- buffer_dtr and seg_valid are combinational from count; they have no extra delay.
- reply_data updates on the edge that samples word_valid and holds until the next word_valid or flush.
- Back-to-back word_valid on consecutive cycles is supported.

## Test plan
- Single segment:
  - Stimulus: after reset, send words 0x01000000_00000001, 0x10, 0x7FFF, 0x2, with encoder_count = 1234 at the header.
  - Required: seg_valid = 1 one cycle after the 4th word; seg_dir = 1, seg_duration = 0x10, seg_increment = 0x7FFF, seg_incinc = 2; reply_data = 1234 after the 3rd word and 0 after the 4th.
- Fill and overflow:
  - Stimulus: seg_ready = 0, push 5 segments with durations 1..5.
  - Required: count = 4 and buffer_dtr = 0 after the 4th; overflow = 1 after the 5th.
  - Then raise seg_ready: pops return durations 1, 2, 3, 4 in order.
- Simultaneous push/pop at count = 2 with seg_ready = 1 on the IIN cycle:
  - Required: count stays 2, FIFO order preserved, pointers wrap correctly after 6 total pushes.
- Non-step header 0xAA00... in HDR:
  - Required: no state change, count unchanged, reply_data = 0.
- Flush:
  - Stimulus: assert flush after the DUR word with 3 segments queued and overflow set.
  - Required: count = 0, seg_valid = 0, overflow = 0, FSM in HDR. The next 4-word step command enqueues normally.
- Async reset:
  - Stimulus: assert wb_rst_i mid-INC between clock edges.
  - Required: outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/move_segment_queue_if.sv
// Segment handshake between the command queue and the DDA step executor.
// master: queue side (drives head segment); slave: DDA side (drives ready).
interface move_segment_queue_if;
    logic        seg_valid;
    logic        seg_ready;
    logic        seg_dir;
    logic [63:0] seg_duration;
    logic [63:0] seg_increment;
    logic [63:0] seg_incinc;

    modport master (
        output seg_valid,
        output seg_dir,
        output seg_duration,
        output seg_increment,
        output seg_incinc,
        input  seg_ready
    );

    modport slave (
        input  seg_valid,
        input  seg_dir,
        input  seg_duration,
        input  seg_increment,
        input  seg_incinc,
        output seg_ready
    );
endinterface

// File: rtl/move_segment_queue.sv
// Assembles 4-word step commands from SPI words and queues segments for the DDA.
// Ports: wb_clk_i/wb_rst_i, word_valid/word_data/encoder_count/flush in,
// reply_data out, seg (segment handshake), count/buffer_dtr/overflow out.
module move_segment_queue #(
    parameter int          DEPTH_BITS = 2,
    parameter logic [7:0]  CMD_STEP   = 8'h01
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  word_valid,
    input  logic [63:0]           word_data,
    input  logic [63:0]           encoder_count,
    input  logic                  flush,
    output logic [63:0]           reply_data,
    move_segment_queue_if.master  seg,
    output logic [DEPTH_BITS:0]   count,
    output logic                  buffer_dtr,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] CNT_ONE = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    localparam logic [1:0] S_HDR = 2'd0;
    localparam logic [1:0] S_DUR = 2'd1;
    localparam logic [1:0] S_INC = 2'd2;
    localparam logic [1:0] S_IIN = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  dir_q, dir_d;
    logic [63:0]           dur_q, dur_d;
    logic [63:0]           inc_q, inc_d;
    logic [63:0]           enc_q, enc_d;
    logic [63:0]           reply_q, reply_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_BITS-1:0] wr_q, wr_d;
    logic [DEPTH_BITS-1:0] rd_q, rd_d;
    logic [DEPTH_BITS:0]   count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  full;

    // {dir, duration, increment, incinc}
    logic [192:0]          mem [DEPTH];
    logic [192:0]          head;

    // Full check uses the pre-pop count: a same-cycle pop never frees a slot.
    assign full = (count_q == DEPTH_C);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dur_d   = dur_q;
        inc_d   = inc_q;
        enc_d   = enc_q;
        reply_d = reply_q;
        ovf_d   = ovf_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (word_valid) begin
            reply_d = '0;
            unique case (1'b1)
                state_q == S_HDR: begin
                    if (word_data[63:56] == CMD_STEP) begin
                        dir_d   = word_data[0];
                        enc_d   = encoder_count;
                        state_d = S_DUR;
                    end
                end
                state_q == S_DUR: begin
                    dur_d   = word_data;
                    state_d = S_INC;
                end
                state_q == S_INC: begin
                    inc_d   = word_data;
                    reply_d = enc_q;
                    state_d = S_IIN;
                end
                default: begin
                    state_d = S_HDR;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            endcase
        end

        pop = (count_q != '0) && seg.seg_ready;

        if (flush) begin
            push    = 1'b0;
            pop     = 1'b0;
            state_d = S_HDR;
            reply_d = '0;
            ovf_d   = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_HDR;
            dir_q   <= 1'b0;
            dur_q   <= '0;
            inc_q   <= '0;
            enc_q   <= '0;
            reply_q <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dur_q   <= dur_d;
            inc_q   <= inc_d;
            enc_q   <= enc_d;
            reply_q <= reply_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage is never reset or cleared; validity is carried by count.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_q] <= {dir_q, dur_q, inc_q, word_data};
        end
    end

    assign head              = mem[rd_q];
    assign seg.seg_valid     = (count_q != '0);
    assign seg.seg_dir       = head[192];
    assign seg.seg_duration  = head[191:128];
    assign seg.seg_increment = head[127:64];
    assign seg.seg_incinc    = head[63:0];

    assign reply_data = reply_q;
    assign count      = count_q;
    assign buffer_dtr = (count_q < DEPTH_C);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_move_segment_queue.sv
// Bench for move_segment_queue: vector table plus scoreboarded sequences.
// Expected segments are queued on the IIN word and compared when popped.
module tb_move_segment_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        word_valid = 1'b0;
    logic [63:0] word_data = '0;
    logic [63:0] enc = '0;
    logic        flush = 1'b0;
    logic [63:0] reply;
    logic [2:0]  count;
    logic        dtr;
    logic        ovf;

    move_segment_queue_if sif ();

    move_segment_queue dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .encoder_count (enc),
        .flush         (flush),
        .reply_data    (reply),
        .seg           (sif.master),
        .count         (count),
        .buffer_dtr    (dtr),
        .overflow      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dir;
        logic [63:0] dur;
        logic [63:0] inc;
        logic [63:0] iin;
    } seg_t;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [63:0] e;
        logic        r;
        logic [2:0]  c;
        logic        sv;
        logic [63:0] rp;
        logic        o;
        logic        dt;
    } vec_t;

    seg_t        sb[$];
    int          ntests = 0;
    int          nfail = 0;
    int          mstate = 0;
    int          mcount = 0;
    logic        mdir = 1'b0;
    logic [63:0] mdur = '0;
    logic [63:0] minc = '0;
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: check any pop against the scoreboard, advance the model,
    // then let the edge happen and settle 1ns past it.
    task automatic cyc();
        logic pp;
        logic acc;
        seg_t s;
        acc = 1'b0;
        pp  = sif.seg_ready && (mcount > 0) && !flush;
        if (pp) begin
            s = sb.pop_front();
            chk("pop_valid", {63'b0, sif.seg_valid}, 64'd1);
            chk("pop_dir", {63'b0, sif.seg_dir}, {63'b0, s.dir});
            chk("pop_dur", sif.seg_duration, s.dur);
            chk("pop_inc", sif.seg_increment, s.inc);
            chk("pop_iin", sif.seg_incinc, s.iin);
        end
        if (flush) begin
            mcount = 0;
            mstate = 0;
            sb.delete();
        end else begin
            if (word_valid) begin
                case (mstate)
                    0: if (word_data[63:56] == 8'h01) begin
                        mdir = word_data[0];
                        mstate = 1;
                    end
                    1: begin mdur = word_data; mstate = 2; end
                    2: begin minc = word_data; mstate = 3; end
                    default: begin
                        mstate = 0;
                        if (mcount < 4) begin
                            sb.push_back({mdir, mdur, minc, word_data});
                            acc = 1'b1;
                        end
                    end
                endcase
            end
            mcount = mcount + int'(acc) - int'(pp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] d);
        word_valid = 1'b1;
        word_data  = d;
        cyc();
        word_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic dir, input logic [63:0] dur,
                            input logic [63:0] inc, input logic [63:0] iin);
        wr({8'h01, 55'b0, dir});
        wr(dur);
        wr(inc);
        wr(iin);
    endtask

    initial begin
        sif.seg_ready = 1'b0;

        tbl[0] = '{1, 64'h0100_0000_0000_0001, 1234, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 64'h10, 1234, 0, 0, 0, 0, 0, 1};
        tbl[2] = '{1, 64'h7FFF, 9999, 0, 0, 0, 1234, 0, 1};
        tbl[3] = '{1, 64'h2, 9999, 0, 1, 1, 0, 0, 1};
        tbl[4] = '{1, 64'hAA00_0000_0000_0000, 77, 0, 1, 1, 0, 0, 1};
        tbl[5] = '{1, 64'h0100_0000_0000_0000, 55, 0, 1, 1, 0, 0, 1};
        tbl[6] = '{1, 64'h20, 66, 0, 1, 1, 0, 0, 1};
        tbl[7] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, 1, 1, 55, 0, 1};
        tbl[8] = '{1, 64'h8000_0000_0000_0000, 66, 1, 1, 1, 0, 0, 1};
        tbl[9] = '{0, 64'h0, 66, 1, 0, 0, 0, 0, 1};

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {61'b0, count}, 64'd0);
        chk("rst_valid", {63'b0, sif.seg_valid}, 64'd0);
        chk("rst_dtr", {63'b0, dtr}, 64'd1);
        chk("rst_ovf", {63'b0, ovf}, 64'd0);
        chk("rst_reply", reply, 64'd0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 10; i++) begin
            word_valid    = tbl[i].v;
            word_data     = tbl[i].d;
            enc           = tbl[i].e;
            sif.seg_ready = tbl[i].r;
            cyc();
            word_valid = 1'b0;
            chk($sformatf("v%0d_count", i), {61'b0, count}, {61'b0, tbl[i].c});
            chk($sformatf("v%0d_valid", i), {63'b0, sif.seg_valid},
                {63'b0, tbl[i].sv});
            chk($sformatf("v%0d_reply", i), reply, tbl[i].rp);
            chk($sformatf("v%0d_ovf", i), {63'b0, ovf}, {63'b0, tbl[i].o});
            chk($sformatf("v%0d_dtr", i), {63'b0, dtr}, {63'b0, tbl[i].dt});
            if (i == 3) begin
                chk("single_dir", {63'b0, sif.seg_dir}, 64'd1);
                chk("single_dur", sif.seg_duration, 64'h10);
                chk("single_inc", sif.seg_increment, 64'h7FFF);
                chk("single_iin", sif.seg_incinc, 64'h2);
            end
        end

        // Fill to DEPTH, then one more is dropped.
        sif.seg_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_cmd(k[0], 64'(k), 64'(k * 16), 64'(k + 100));
            if (k == 4) begin
                chk("fill_count", {61'b0, count}, 64'd4);
                chk("fill_dtr", {63'b0, dtr}, 64'd0);
                chk("fill_ovf", {63'b0, ovf}, 64'd0);
            end
        end
        chk("ovf_set", {63'b0, ovf}, 64'd1);
        chk("ovf_count", {61'b0, count}, 64'd4);
        sif.seg_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_count", {61'b0, count}, 64'd0);
        chk("drain_valid", {63'b0, sif.seg_valid}, 64'd0);
        cyc();
        chk("empty_pop", {61'b0, count}, 64'd0);
        chk("ovf_sticky", {63'b0, ovf}, 64'd1);

        // Push and pop on the same edge at count 2.
        sif.seg_ready = 1'b0;
        send_cmd(1'b0, 64'd6, 64'h60, 64'h106);
        send_cmd(1'b1, 64'd7, 64'h70, 64'h107);
        chk("pp_pre", {61'b0, count}, 64'd2);
        wr({8'h01, 56'b0});
        wr(64'd8);
        wr(64'h80);
        sif.seg_ready = 1'b1;
        wr(64'h108);
        sif.seg_ready = 1'b0;
        chk("pp_count", {61'b0, count}, 64'd2);
        sif.seg_ready = 1'b1;
        repeat (2) cyc();
        chk("pp_drain", {61'b0, count}, 64'd0);

        // Flush mid-command with segments queued and overflow set.
        sif.seg_ready = 1'b0;
        send_cmd(1'b1, 64'd9, 64'h90, 64'h109);
        send_cmd(1'b0, 64'd10, 64'hA0, 64'h10A);
        send_cmd(1'b1, 64'd11, 64'hB0, 64'h10B);
        chk("fl_pre_count", {61'b0, count}, 64'd3);
        chk("fl_pre_ovf", {63'b0, ovf}, 64'd1);
        enc = 64'd777;
        wr({8'h01, 56'b1});
        wr(64'd12);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_count", {61'b0, count}, 64'd0);
        chk("fl_valid", {63'b0, sif.seg_valid}, 64'd0);
        chk("fl_ovf", {63'b0, ovf}, 64'd0);
        chk("fl_reply", reply, 64'd0);
        chk("fl_dtr", {63'b0, dtr}, 64'd1);
        enc = 64'd4321;
        wr({8'h01, 56'b0});
        wr(64'd13);
        wr(64'hD0);
        chk("fl_snap", reply, 64'd4321);
        wr(64'h10D);
        chk("fl_after", {61'b0, count}, 64'd1);
        sif.seg_ready = 1'b1;
        cyc();
        chk("fl_drain", {61'b0, count}, 64'd0);

        // Async reset between edges, mid-command, with full queue and overflow.
        sif.seg_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_cmd(1'b0, 64'(20 + k), 64'h1, 64'h2);
        end
        chk("ar_pre_ovf", {63'b0, ovf}, 64'd1);
        enc = 64'd5;
        wr({8'h01, 56'b1});
        wr(64'd30);
        #2 rst = 1'b1;
        #1;
        chk("ar_count", {61'b0, count}, 64'd0);
        chk("ar_valid", {63'b0, sif.seg_valid}, 64'd0);
        chk("ar_dtr", {63'b0, dtr}, 64'd1);
        chk("ar_ovf", {63'b0, ovf}, 64'd0);
        chk("ar_reply", reply, 64'd0);
        mcount = 0;
        mstate = 0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        enc = 64'd31;
        wr({8'h01, 56'b1});
        wr(64'd32);
        wr(64'd33);
        chk("ar_snap", reply, 64'd31);
        wr(64'd34);
        chk("ar_after", {61'b0, count}, 64'd1);
        sif.seg_ready = 1'b1;
        cyc();
        chk("ar_drain", {61'b0, count}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
